dev_bus_arbiter: RTL and testbench
==================================

# dev_bus_arbiter

Two-master arbiter sharing the single CPU-side device bus in front of `devctrl` (SRAM, flash, VGA, serial, USB) between two requesters. Port 0 is the CPU data port; port 1 is a DMA/refill engine. It grants the bus round-robin and latches the winning request. It sequences one downstream transaction, honouring `devBusy_i`, and returns registered read data with a one-cycle acknowledge.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum ACCESS cycles before abort. Used only with `ARB_TIMEOUT_EN`.
- `ERR_DATA`, default 32'hDEADBEEF: read data returned on timeout.

Ports:
- `clk`  in  1  system clock (25 MHz domain)
- `rst_n`  in  1  reset, asynchronous, active-low
- `m0_req_i` / `m1_req_i`  in  1  request level; held until ack
- `m0_write_i` / `m1_write_i`  in  1  1 = write, 0 = read
- `m0_addr_i` / `m1_addr_i`  in  32  physical address
- `m0_wdata_i` / `m1_wdata_i`  in  32  write data
- `m0_be_i` / `m1_be_i`  in  4  byte select
- `m0_ack_o` / `m1_ack_o`  out  1  one-cycle completion pulse
- `m0_rdata_o` / `m1_rdata_o`  out  32  read data, valid during ack
- `m0_err_o` / `m1_err_o`  out  1  timeout flag, valid during ack
- `devEnable_o`  out  1  downstream enable
- `devWrite_o`  out  1  downstream write
- `devPhysicalAddr_o`  out  32  downstream address
- `devDataSave_o`  out  32  downstream write data
- `devByteSelect_o`  out  4  downstream byte select
- `devBusy_i`  in  1  downstream busy
- `devDataLoad_i`  in  32  downstream read data
- `grant_o`  out  2  one-hot owner, 00 when idle (debug/LED)

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE.** Sample both requests.
  - If only one request is high, grant it.
  - If both are high, grant the master that is not `lastGrant`.
  - On grant, latch write/addr/wdata/be into the command register, set `lastGrant`, go to ACCESS.
- **ACCESS.**
  - Outputs: `devEnable_o`=1; dev* driven from the command register.
  - If `devBusy_i`=0: capture `devDataLoad_i` into the rdata register (reads only; writes leave it unchanged) and go to RESP.
  - Otherwise stay in ACCESS.
- **RESP.**
  - `devEnable_o`=0; the granted master's `ack_o`=1.
  - Both masters' requests are ignored this cycle.
  - Go to IDLE.
- `mX_rdata_o` comes from one shared rdata register; it is meaningful only while `mX_ack_o`=1. `mX_err_o` is 0 unless timed out.
- The non-granted master's request stays pending. Round-robin guarantees it wins the next arbitration, so there is no starvation.
- Master inputs are don't-care after grant because the command is latched.
- A request still high in the IDLE cycle after its own ack counts as a new request.
- Reset (any time, including mid-ACCESS):
  - state=IDLE, `lastGrant`=1 (so m0 wins the first tie);
  - all outputs 0, rdata register 0, timeout counter 0.
  - The downstream transaction is abandoned without ack.

## Timing
- Request high in cycle N (IDLE) → ACCESS in N+1 → RESP/ack in N+2 when `devBusy_i`=0 in N+1.
- Each busy cycle adds one cycle of latency.
- Minimum spacing of back-to-back transactions by one master: 3 cycles (ack at N+2, next ACCESS at N+4).
- dev* outputs are registered-state driven and glitch-free.
- `devEnable_o` is high exactly for the ACCESS cycles.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - ACCESS counts cycles and clears on entering ACCESS.
  - When the count reaches `TIMEOUT_CYCLES` with `devBusy_i` still 1: go to RESP with rdata=`ERR_DATA` and `err_o`=1.
- Undefined: no counter, `err_o` tied 0, ACCESS waits indefinitely.

## Test plan
- Single read, m0, `devBusy_i`=0, `devDataLoad_i`=32'h12345678, addr 32'h80000010 → `devEnable_o` high 1 cycle; `m0_ack_o` pulses at N+2 with `m0_rdata_o`=32'h12345678; `grant_o`=01 during ACCESS.
- m1 write, addr 32'h80400000, data 32'hA5A5A5A5, be 4'b0011, `devBusy_i` high 3 cycles → dev* hold those values 4 ACCESS cycles; `m1_ack_o` at N+5; rdata register unchanged.
- Both masters request continuously from reset → grants alternate m0, m1, m0, m1; each ack 3 cycles apart.
- m1 requests during m0's ACCESS → m1 is granted in the IDLE right after m0's RESP even though m0 re-requests.
- `rst_n` low mid-ACCESS → all outputs 0 immediately (asynchronous); no ack issued; the first tie after release is granted to m0.
- With `ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `devBusy_i` stuck 1 → ack at cycle 16 of ACCESS with `err_o`=1 and `rdata_o`=32'hDEADBEEF. Without the macro → no ack after 100 cycles.

Source files
------------

// File: rtl/dev_bus_arbiter_if.sv
// dev_bus_arbiter_if: bundles both master request ports, the downstream
//   device bus and the debug grant vector into one connection.
// Ports: m0_*/m1_* request/ack/read-data, dev* downstream command/status,
//   grant_o owner. slave = arbiter view, master = environment view.
interface dev_bus_arbiter_if;
  // Master 0 (CPU data port)
  logic        m0_req_i;
  logic        m0_write_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wdata_i;
  logic [3:0]  m0_be_i;
  logic        m0_ack_o;
  logic [31:0] m0_rdata_o;
  logic        m0_err_o;
  // Master 1 (DMA / refill engine)
  logic        m1_req_i;
  logic        m1_write_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic [3:0]  m1_be_i;
  logic        m1_ack_o;
  logic [31:0] m1_rdata_o;
  logic        m1_err_o;
  // Downstream device bus
  logic        devEnable_o;
  logic        devWrite_o;
  logic [31:0] devPhysicalAddr_o;
  logic [31:0] devDataSave_o;
  logic [3:0]  devByteSelect_o;
  logic        devBusy_i;
  logic [31:0] devDataLoad_i;
  // Debug
  logic [1:0]  grant_o;

  modport slave (
    input  m0_req_i, m0_write_i, m0_addr_i, m0_wdata_i, m0_be_i,
    output m0_ack_o, m0_rdata_o, m0_err_o,
    input  m1_req_i, m1_write_i, m1_addr_i, m1_wdata_i, m1_be_i,
    output m1_ack_o, m1_rdata_o, m1_err_o,
    output devEnable_o, devWrite_o, devPhysicalAddr_o, devDataSave_o, devByteSelect_o,
    input  devBusy_i, devDataLoad_i,
    output grant_o
  );

  modport master (
    output m0_req_i, m0_write_i, m0_addr_i, m0_wdata_i, m0_be_i,
    input  m0_ack_o, m0_rdata_o, m0_err_o,
    output m1_req_i, m1_write_i, m1_addr_i, m1_wdata_i, m1_be_i,
    input  m1_ack_o, m1_rdata_o, m1_err_o,
    input  devEnable_o, devWrite_o, devPhysicalAddr_o, devDataSave_o, devByteSelect_o,
    output devBusy_i, devDataLoad_i,
    input  grant_o
  );
endinterface

// File: rtl/dev_bus_arbiter.sv
// dev_bus_arbiter: round-robin arbiter giving two masters one shared device bus.
// Latency: request in IDLE cycle N -> ACCESS N+1 -> ack N+2, plus one cycle per busy cycle.
// Backpressure: devBusy_i stalls in ACCESS; losing master's request stays pending (level held).
// Ports: clk, rst_n (async active-low), bus (dev_bus_arbiter_if.slave).
// Optional feature: define ARB_TIMEOUT_EN to abort an ACCESS after TIMEOUT_CYCLES
//   busy cycles, returning ERR_DATA with err set; otherwise ACCESS waits forever.
module dev_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               rst_n,
  dev_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("dev_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic        owner_q, owner_d;          // 0 = m0, 1 = m1
  logic        last_grant_q, last_grant_d;
  logic        cmd_write_q, cmd_write_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic [3:0]  cmd_be_q, cmd_be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        pick_m1;
  logic        timeout_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  // Held at zero outside ACCESS, so it is clear on every ACCESS entry and
  // equals (ACCESS cycles already spent) while in ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q != ACCESS) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // Fires in the last permitted ACCESS cycle, bounding ACCESS to TIMEOUT_CYCLES.
  assign timeout_hit = (state_q == ACCESS) && bus.devBusy_i &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Tie goes to the master that did not win last time.
  assign pick_m1 = bus.m1_req_i && (!bus.m0_req_i || !last_grant_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_be_q     <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_be_q     <= cmd_be_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_be_d     = cmd_be_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.m0_req_i || bus.m1_req_i) begin
          owner_d      = pick_m1;
          last_grant_d = pick_m1;
          cmd_write_d  = pick_m1 ? bus.m1_write_i : bus.m0_write_i;
          cmd_addr_d   = pick_m1 ? bus.m1_addr_i  : bus.m0_addr_i;
          cmd_wdata_d  = pick_m1 ? bus.m1_wdata_i : bus.m0_wdata_i;
          cmd_be_d     = pick_m1 ? bus.m1_be_i    : bus.m0_be_i;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (timeout_hit) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (!bus.devBusy_i) begin
          // Writes leave the shared read-data register untouched.
          if (!cmd_write_q) begin
            rdata_d = bus.devDataLoad_i;
          end
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        // Requests are not sampled here; a held request re-arbitrates in IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs come straight from registers or single-bit state decodes.
  assign bus.devEnable_o       = (state_q == ACCESS);
  assign bus.devWrite_o        = cmd_write_q;
  assign bus.devPhysicalAddr_o = cmd_addr_q;
  assign bus.devDataSave_o     = cmd_wdata_q;
  assign bus.devByteSelect_o   = cmd_be_q;

  assign bus.grant_o    = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

  assign bus.m0_ack_o   = (state_q == RESP) && !owner_q;
  assign bus.m1_ack_o   = (state_q == RESP) &&  owner_q;
  assign bus.m0_rdata_o = rdata_q;
  assign bus.m1_rdata_o = rdata_q;
  assign bus.m0_err_o   = err_q && bus.m0_ack_o;
  assign bus.m1_err_o   = err_q && bus.m1_ack_o;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
`timescale 1ns/1ps
module tb_dev_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dev_bus_arbiter_if bus ();

  dev_bus_arbiter #(
    .TIMEOUT_CYCLES(16),
    .ERR_DATA      (32'hDEADBEEF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int          master;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
    int          ack_cyc;
    int          n_en;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  int   busy_left = 0;
  bit   busy_stuck = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input bit req, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (m == 0) begin
      bus.m0_req_i = req; bus.m0_write_i = wr; bus.m0_addr_i = addr;
      bus.m0_wdata_i = wdata; bus.m0_be_i = be;
    end else begin
      bus.m1_req_i = req; bus.m1_write_i = wr; bus.m1_addr_i = addr;
      bus.m1_wdata_i = wdata; bus.m1_be_i = be;
    end
  endtask

  task automatic push(input int m, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] rdata, input bit err,
                      input int ack_cyc, input int n_en);
    exp_t e;
    e.master = m; e.write = wr; e.addr = addr; e.wdata = wdata; e.be = be;
    e.rdata = rdata; e.err = err; e.ack_cyc = ack_cyc; e.n_en = n_en;
    sb.push_back(e);
  endtask

  // Bounded wait for every expected ack; leaves the caller 1ns after a posedge.
  task automatic wait_drain(input int max_cyc, input string name);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({"drain_", name}, sb.size(), 0);
    sb.delete();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream busy model: a burst of busy cycles at the start of ACCESS, or stuck.
  initial forever begin
    @(negedge clk);
    if (busy_stuck) begin
      bus.devBusy_i = 1'b1;
    end else if (bus.devEnable_o && busy_left > 0) begin
      bus.devBusy_i = 1'b1;
      busy_left--;
    end else begin
      bus.devBusy_i = 1'b0;
    end
  end

  // Monitor: checks the command on the device bus against the scoreboard head,
  // and pops/compares on every ack.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      en_cnt = 0;
    end else begin
      if (bus.devEnable_o) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_access actual=enable required=idle (cycle %0d)", cyc);
        end else begin
          check("dev_cmd",
                {bus.devWrite_o, bus.devPhysicalAddr_o, bus.devDataSave_o, bus.devByteSelect_o},
                {sb[0].write, sb[0].addr, sb[0].wdata, sb[0].be});
          check("grant_access", bus.grant_o, (sb[0].master == 1) ? 2'b10 : 2'b01);
          en_cnt++;
        end
      end
      if (bus.m0_ack_o || bus.m1_ack_o) begin
        if (bus.m0_ack_o && bus.m1_ack_o) begin
          checks++; failures++;
          $display("FAIL ack_both actual=11 required=one-hot (cycle %0d)", cyc);
        end else if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack actual=m%0d required=none (cycle %0d)",
                   bus.m1_ack_o ? 1 : 0, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_master", bus.m1_ack_o ? 1 : 0, e.master);
          check("ack_cycle", cyc, e.ack_cyc);
          check("ack_rdata", bus.m1_ack_o ? bus.m1_rdata_o : bus.m0_rdata_o, e.rdata);
          check("ack_err", bus.m1_ack_o ? bus.m1_err_o : bus.m0_err_o, e.err);
          check("enable_cycles", en_cnt, e.n_en);
          check("ack_no_enable", bus.devEnable_o, 0);
        end
        en_cnt = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},    bus.devEnable_o, 0);
    check({tag, "_dev"},   {bus.devWrite_o, bus.devPhysicalAddr_o, bus.devDataSave_o, bus.devByteSelect_o}, 0);
    check({tag, "_grant"}, bus.grant_o, 0);
    check({tag, "_ack"},   {bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o}, 0);
    check({tag, "_rdata"}, {bus.m0_rdata_o, bus.m1_rdata_o}, 0);
  endtask

  initial begin
    int c;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    bus.devBusy_i = 1'b0;
    bus.devDataLoad_i = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    tick();

    // Single m0 read, no busy: ack two cycles after the request.
    c = cyc;
    bus.devDataLoad_i = 32'h12345678;
    drive(0, 1, 0, 32'h80000010, 32'h0, 4'hF);
    push(0, 0, 32'h80000010, 32'h0, 4'hF, 32'h12345678, 0, c + 2, 1);
    wait_drain(20, "m0_read");
    drive(0, 0, 0, 0, 0, 0);

    // m1 write with three busy cycles; read data register must keep the last read.
    c = cyc;
    busy_left = 3;
    bus.devDataLoad_i = 32'hFFFF0000;
    drive(1, 1, 1, 32'h80400000, 32'hA5A5A5A5, 4'b0011);
    push(1, 1, 32'h80400000, 32'hA5A5A5A5, 4'b0011, 32'h12345678, 0, c + 5, 4);
    wait_drain(20, "m1_write_busy");
    drive(1, 0, 0, 0, 0, 0);

    // Both masters requesting continuously: strict alternation, acks 3 cycles apart.
    c = cyc;
    bus.devDataLoad_i = 32'h00001111;
    drive(0, 1, 0, 32'h80000100, 32'h0, 4'hF);
    drive(1, 1, 0, 32'h80000200, 32'h0, 4'hF);
    push(0, 0, 32'h80000100, 32'h0, 4'hF, 32'h00001111, 0, c + 2, 1);
    push(1, 0, 32'h80000200, 32'h0, 4'hF, 32'h00001111, 0, c + 5, 1);
    push(0, 0, 32'h80000100, 32'h0, 4'hF, 32'h00001111, 0, c + 8, 1);
    push(1, 0, 32'h80000200, 32'h0, 4'hF, 32'h00001111, 0, c + 11, 1);
    wait_drain(40, "alternate");
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    // m1 arrives during m0's ACCESS; m0 keeps requesting yet m1 wins next.
    c = cyc;
    busy_left = 1;
    bus.devDataLoad_i = 32'h00002222;
    drive(0, 1, 0, 32'h80000300, 32'h0, 4'hF);
    push(0, 0, 32'h80000300, 32'h0, 4'hF, 32'h00002222, 0, c + 3, 2);
    push(1, 0, 32'h80000400, 32'h0, 4'hF, 32'h00002222, 0, c + 6, 1);
    push(0, 0, 32'h80000300, 32'h0, 4'hF, 32'h00002222, 0, c + 9, 1);
    tick();
    drive(1, 1, 0, 32'h80000400, 32'h0, 4'hF);
    wait_drain(40, "late_m1");
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    // Reset in the middle of ACCESS: outputs clear at once, no ack, m0 wins next tie.
    busy_stuck = 1'b1;
    drive(0, 1, 1, 32'h80000500, 32'h11112222, 4'b1111);
    push(0, 1, 32'h80000500, 32'h11112222, 4'b1111, 32'h0, 0, cyc + 99, 1);
    tick();
    tick();
    check("pre_reset_access", bus.devEnable_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    sb.delete();
    busy_stuck = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    c = cyc;
    bus.devDataLoad_i = 32'h33334444;
    drive(0, 1, 0, 32'h80000600, 32'h0, 4'hF);
    drive(1, 1, 0, 32'h80000700, 32'h0, 4'hF);
    push(0, 0, 32'h80000600, 32'h0, 4'hF, 32'h33334444, 0, c + 2, 1);
    push(1, 0, 32'h80000700, 32'h0, 4'hF, 32'h33334444, 0, c + 5, 1);
    wait_drain(40, "after_reset");
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    // Device stuck busy.
    c = cyc;
    busy_stuck = 1'b1;
    bus.devDataLoad_i = 32'h55556666;
    drive(1, 1, 0, 32'h80000800, 32'h0, 4'hF);
`ifdef ARB_TIMEOUT_EN
    push(1, 0, 32'h80000800, 32'h0, 4'hF, 32'hDEADBEEF, 1, c + 17, 16);
    wait_drain(40, "timeout");
    drive(1, 0, 0, 0, 0, 0);
    busy_stuck = 1'b0;
`else
    push(1, 0, 32'h80000800, 32'h0, 4'hF, 32'h55556666, 0, c + 101, 100);
    repeat (100) tick();
    check("no_ack_stuck", sb.size(), 1);
    busy_stuck = 1'b0;
    wait_drain(10, "stuck_release");
    drive(1, 0, 0, 0, 0, 0);
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
